sram_bitmap_loader: RTL

//  Upstream neighbour of the SXGA rotozoom scan-out: owns the SRAM pins and loads the 512x512x16 bitmap into SRAM.

---
 rtl/sram_bitmap_loader.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/sram_bitmap_loader.sv
// SRAM owner for the rotozoom bitmap: buffers host pixel words and writes them in video-free gaps.
// Optional macro SRAM_LOADER_WCNT_EN adds the wcnt words-written counter port.
module sram_bitmap_loader #(
    parameter int unsigned FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_start,
    input  logic [17:0] start_addr,
    input  logic        wr_valid,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    output logic        busy,
    output logic        err_collide,
    input  logic        vid_req,
    input  logic        vid_guard,
    input  logic [17:0] vid_addr,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_lb_n,
    output logic        sram_ub_n
`ifdef SRAM_LOADER_WCNT_EN
    ,
    output logic [17:0] wcnt
`endif
);

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 1 << FIFO_AW;
    localparam int unsigned CNT_W  = FIFO_AW + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // write FIFO storage and pointers
    logic [DATA_W-1:0]  fifo_mem_q [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] wptr_q,      wptr_d;
    logic              err_q,       err_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] dq_q,        dq_d;
    logic              dq_oe_q,     dq_oe_d;
    logic              oe_n_q,      oe_n_d;
    logic              we_n_q,      we_n_d;
    logic              lb_n_q,      lb_n_d;
    logic              ub_n_q,      ub_n_d;
    logic              start_ok;

    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == CNT_W'(0));
    assign wr_ready   = !fifo_full && !rst;
    assign push       = wr_valid && wr_ready;
    assign busy       = !fifo_empty || (state_q != ST_IDLE);
    assign start_ok   = cmd_start && !busy;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // video reads win in IDLE; a started write always runs SETUP/STROBE/HOLD to completion
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        wptr_d  = wptr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        dq_d    = dq_q;
        dq_oe_d = 1'b0;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (vid_req) begin
                    addr_d = vid_addr;
                    oe_n_d = 1'b0;
                    lb_n_d = 1'b0;
                    ub_n_d = 1'b0;
                end else if (!fifo_empty && !vid_guard) begin
                    state_d = ST_SETUP;
                    pop     = 1'b1;
                    addr_d  = wptr_q;
                    dq_d    = fifo_mem_q[rd_ptr_q];
                    dq_oe_d = 1'b1;
                    lb_n_d  = 1'b0;
                    ub_n_d  = 1'b0;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                dq_oe_d = 1'b1;
                we_n_d  = 1'b0;
                lb_n_d  = 1'b0;
                ub_n_d  = 1'b0;
                if (vid_req) begin
                    err_d = 1'b1;
                end
            end
            ST_STROBE: begin
                state_d = ST_HOLD;
                dq_oe_d = 1'b1;
                lb_n_d  = 1'b0;
                ub_n_d  = 1'b0;
                if (vid_req) begin
                    err_d = 1'b1;
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
                wptr_d  = wptr_q + ADDR_W'(1);
                if (vid_req) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_ok) begin
            wptr_d = start_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            dq_q    <= '0;
            dq_oe_q <= 1'b0;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            dq_q    <= dq_d;
            dq_oe_q <= dq_oe_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            lb_n_q  <= lb_n_d;
            ub_n_q  <= ub_n_d;
        end
    end

    assign err_collide = err_q;
    assign sram_addr   = addr_q;
    assign sram_dq_o   = dq_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_lb_n   = lb_n_q;
    assign sram_ub_n   = ub_n_q;

`ifdef SRAM_LOADER_WCNT_EN
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;

    always_comb begin
        wcnt_d = wcnt_q;
        if (start_ok) begin
            wcnt_d = '0;
        end else if (state_q == ST_HOLD) begin
            wcnt_d = wcnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign wcnt = wcnt_q;
`endif

endmodule
